ofm_addr_controller: RTL and testbench
======================================

# ofm_addr_controller

Write-side address generator for the output feature map (OFM) buffer. It accepts the result stream draining from the systolic array, one value per valid cycle. For each value it produces a registered buffer write (address, data, write enable) in channel-major OFM layout, and it signals completion of the layer. It is the writer counterpart of the IFM read-address controller: that block feeds the array, this one stores its results.

## Interface
- OFM_SIZE, 26: output feature map height = width.
- OFM_CHANNEL, 20: number of output channels.
- TILE, 16: channels produced per array pass (array width); 1..16.
- DATA_WIDTH, 16: result word width.
- ADDR_WIDTH, 14: OFM buffer address width; must satisfy OFM_SIZE²·OFM_CHANNEL ≤ 2^ADDR_WIDTH.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  start of a layer; sampled in IDLE only.
- valid  in  1  result word on in_data is valid this cycle.
- in_data  in  DATA_WIDTH  result word from the array.
- size  out  5  channel count of the current group, min(TILE, OFM_CHANNEL − group_base).
- ofm_addr  out  ADDR_WIDTH  write address.
- ofm_data  out  DATA_WIDTH  write data.
- write_en  out  1  buffer write strobe.
- done  out  1  one-cycle pulse on the final write of the layer.

## Operation
- Write order: channel group g (base = g·TILE), then pixel p = 0..PLANE−1 (PLANE = OFM_SIZE²), then channel c = 0..size−1.
- Address: (base + c)·PLANE + p.
- Address arithmetic is incremental; no multiplier.
  - Within a pixel: addr += PLANE.
  - At a pixel end: addr = grp_addr + p + 1.
  - At a group end: grp_addr += TILE·PLANE, and addr takes that new value.
- States:
  - IDLE: outputs idle and valid ignored. load=1 → RUN; clear the pixel and channel counters, grp_addr and addr; set size = min(TILE, OFM_CHANNEL).
  - RUN: each valid=1 cycle accepts one word and advances the counters. When the accepted word is the last one (last group, p = PLANE−1, c = size−1) → IDLE.
- The block is always ready in RUN; there is no backpressure. valid=0 cycles stall the counters.
- load while in RUN is ignored. Issuing load in the same cycle as the final accept does not restart; the next layer needs load in IDLE.
- The last group has size = OFM_CHANNEL − (NUM_GROUPS−1)·TILE. size updates on the cycle after the last accept of the preceding group.
- Reset (at any time, including mid-layer): state IDLE; size=0, ofm_addr=0, ofm_data=0, write_en=0, done=0; all counters 0.

## Timing
- Latency 1: valid/in_data sampled at edge n produce write_en=1 with the matching ofm_addr/ofm_data during cycle n+1.
- Outputs are registered; no combinational path from inputs to outputs.
- write_en=0 in every cycle not following an accepted word. ofm_addr/ofm_data hold their last value when write_en=0.
- done=1 in the same cycle as the final write_en and for that cycle only. The state is IDLE in that cycle.
- First accept is possible in the cycle right after load is sampled.
- Total writes per layer is exactly PLANE·OFM_CHANNEL. The address never exceeds PLANE·OFM_CHANNEL−1.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN);
  - derived constants PLANE, GROUP_STRIDE = TILE·PLANE, NUM_GROUPS = ceil(OFM_CHANNEL/TILE), LAST_GROUP_SIZE, TOTAL_WRITES.
  - The IFM controller uses the same package.
- Single module; counters and address accumulator are inline. No sub-module is warranted.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, toggling valid/load → all outputs 0, no write_en.
- Small layer, continuous stream (OFM_SIZE=2, OFM_CHANNEL=20, TILE=16, PLANE=4):
  - load then 80 consecutive valids.
  - Addresses 0,4,…,60,1,5,…,61,…,3,…,63; then 64,68,72,76,65,…,79.
  - size 16 then 4; done with addr 79; exactly 80 write_en.
- Bubbles: same layer with random valid gaps → identical address/data sequence, write_en only after accepted words, done once.
- Ignored inputs:
  - valid pulses in IDLE → no writes.
  - load pulse mid-RUN → sequence unaffected.
- Reset mid-layer: after 30 accepts assert rst_n=0 one cycle, then load and stream → addresses restart at 0, full 80-write sequence.
- Default parameters: load plus 13520 valids → last addr 13519, done once, no address ≥ 13520; groups of size 16 then 4.

Source files
------------

// File: rtl/ofm_addr_controller_pkg.sv
// Shared definitions for the IFM/OFM address controllers: FSM state type and
// layer-geometry helpers, with constants for the default 26x26x20 layer.
package ofm_addr_controller_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int calc_plane(input int ofm_size);
        return ofm_size * ofm_size;
    endfunction

    function automatic int calc_stride(input int ofm_size, input int tile);
        return tile * ofm_size * ofm_size;
    endfunction

    function automatic int calc_groups(input int channels, input int tile);
        return (channels + tile - 1) / tile;
    endfunction

    function automatic int calc_last_size(input int channels, input int tile);
        return channels - (calc_groups(channels, tile) - 1) * tile;
    endfunction

    function automatic int calc_total(input int ofm_size, input int channels);
        return ofm_size * ofm_size * channels;
    endfunction

    localparam int PLANE           = calc_plane(26);
    localparam int GROUP_STRIDE    = calc_stride(26, 16);
    localparam int NUM_GROUPS      = calc_groups(20, 16);
    localparam int LAST_GROUP_SIZE = calc_last_size(20, 16);
    localparam int TOTAL_WRITES    = calc_total(26, 20);

endpackage

// File: rtl/ofm_addr_controller.sv
// OFM buffer write-address generator: stores the array result stream in
// channel-major layout, one registered write per accepted word.
module ofm_addr_controller
    import ofm_addr_controller_pkg::*;
#(
    parameter int OFM_SIZE    = 26,
    parameter int OFM_CHANNEL = 20,
    parameter int TILE        = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [4:0]            size,
    output logic [ADDR_WIDTH-1:0] ofm_addr,
    output logic [DATA_WIDTH-1:0] ofm_data,
    output logic                  write_en,
    output logic                  done
);

    localparam int CFG_PLANE  = calc_plane(OFM_SIZE);
    localparam int CFG_GROUPS = calc_groups(OFM_CHANNEL, TILE);
    localparam int CFG_LAST   = calc_last_size(OFM_CHANNEL, TILE);
    localparam int PIX_W      = (CFG_PLANE > 1) ? $clog2(CFG_PLANE) : 1;
    localparam int GRP_W      = (CFG_GROUPS > 1) ? $clog2(CFG_GROUPS) : 1;

    localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(calc_stride(OFM_SIZE, TILE));
    localparam logic [ADDR_WIDTH-1:0] PLANE_STEP = ADDR_WIDTH'(CFG_PLANE);
    localparam logic [4:0]            FIRST_SIZE = 5'((TILE < OFM_CHANNEL) ? TILE : OFM_CHANNEL);
    localparam logic [4:0]            FULL_SIZE  = 5'(TILE);
    localparam logic [4:0]            LAST_SIZE  = 5'(CFG_LAST);
    localparam logic [PIX_W-1:0]      PIX_LAST   = PIX_W'(CFG_PLANE - 1);
    localparam logic [GRP_W-1:0]      GRP_LAST   = GRP_W'(CFG_GROUPS - 1);
    localparam logic [GRP_W-1:0]      GRP_PENULT = GRP_W'(CFG_GROUPS - 2);

    state_t                r_state;
    logic [PIX_W-1:0]      r_pix;
    logic [4:0]            r_ch;
    logic [GRP_W-1:0]      r_grp;
    logic [ADDR_WIDTH-1:0] r_grp_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [4:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_we;
    logic                  r_done;

    logic w_ch_end;
    logic w_pix_end;
    logic w_grp_last;

    assign w_ch_end   = (r_ch == r_size - 5'd1);
    assign w_pix_end  = (r_pix == PIX_LAST);
    assign w_grp_last = (r_grp == GRP_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pix      <= '0;
            r_ch       <= '0;
            r_grp      <= '0;
            r_grp_addr <= '0;
            r_addr     <= '0;
            r_size     <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_state    <= RUN;
                        r_pix      <= '0;
                        r_ch       <= '0;
                        r_grp      <= '0;
                        r_grp_addr <= '0;
                        r_addr     <= '0;
                        r_size     <= FIRST_SIZE;
                    end
                end
                RUN: begin
                    if (valid) begin
                        r_wr_addr <= r_addr;
                        r_wr_data <= in_data;
                        r_we      <= 1'b1;
                        if (!w_ch_end) begin
                            r_ch   <= r_ch + 5'd1;
                            r_addr <= r_addr + PLANE_STEP;
                        end else if (!w_pix_end) begin
                            r_ch   <= '0;
                            r_pix  <= r_pix + PIX_W'(1);
                            r_addr <= r_grp_addr + ADDR_WIDTH'(r_pix) + ADDR_WIDTH'(1);
                        end else if (!w_grp_last) begin
                            // Next group starts TILE planes further on; the last group may be narrower.
                            r_ch       <= '0;
                            r_pix      <= '0;
                            r_grp      <= r_grp + GRP_W'(1);
                            r_grp_addr <= r_grp_addr + STRIDE;
                            r_addr     <= r_grp_addr + STRIDE;
                            r_size     <= (r_grp == GRP_PENULT) ? LAST_SIZE : FULL_SIZE;
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign size     = r_size;
    assign ofm_addr = r_wr_addr;
    assign ofm_data = r_wr_data;
    assign write_en = r_we;
    assign done     = r_done;

endmodule

// File: tb/tb_ofm_addr_controller.sv
// Randomized self-checking bench: a small 2x2x20 layer instance for scenario
// tests and a default 26x26x20 instance for a full-size layer.
module tb_ofm_addr_controller;

    localparam int S_OSZ = 2;
    localparam int S_OCH = 20;
    localparam int D_OSZ = 26;
    localparam int D_OCH = 20;
    localparam int TL    = 16;
    localparam int S_TOT = S_OSZ * S_OSZ * S_OCH;
    localparam int D_TOT = D_OSZ * D_OSZ * D_OCH;

    logic        clk;
    logic        s_rst_n, s_load, s_valid;
    logic [15:0] s_data;
    logic [4:0]  s_size;
    logic [6:0]  s_addr;
    logic [15:0] s_odata;
    logic        s_we, s_done;

    logic        d_rst_n, d_load, d_valid;
    logic [15:0] d_data;
    logic [4:0]  d_size;
    logic [13:0] d_addr;
    logic [15:0] d_odata;
    logic        d_we, d_done;

    int n_chk;
    int n_fail;

    ofm_addr_controller #(
        .OFM_SIZE(S_OSZ), .OFM_CHANNEL(S_OCH), .TILE(TL), .DATA_WIDTH(16), .ADDR_WIDTH(7)
    ) u_small (
        .clk(clk), .rst_n(s_rst_n), .load(s_load), .valid(s_valid), .in_data(s_data),
        .size(s_size), .ofm_addr(s_addr), .ofm_data(s_odata), .write_en(s_we), .done(s_done)
    );

    ofm_addr_controller #(
        .OFM_SIZE(D_OSZ), .OFM_CHANNEL(D_OCH), .TILE(TL), .DATA_WIDTH(16), .ADDR_WIDTH(14)
    ) u_dflt (
        .clk(clk), .rst_n(d_rst_n), .load(d_load), .valid(d_valid), .in_data(d_data),
        .size(d_size), .ofm_addr(d_addr), .ofm_data(d_odata), .write_en(d_we), .done(d_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: write k of a layer, in group -> pixel -> channel order.
    function automatic int m_gsize(input int g, input int och);
        int rem;
        rem = och - g * TL;
        return (rem < TL) ? rem : TL;
    endfunction

    function automatic int m_addr(input int k, input int osz, input int och);
        int plane, g, off, gs;
        plane = osz * osz;
        g     = k / (TL * plane);
        off   = k - g * TL * plane;
        gs    = m_gsize(g, och);
        return (g * TL + off % gs) * plane + off / gs;
    endfunction

    // size visible alongside write k already reflects the group of the next accept.
    function automatic int m_size_at(input int k, input int osz, input int och);
        int plane, kk;
        plane = osz * osz;
        kk = (k == plane * och - 1) ? k : k + 1;
        return m_gsize(kk / (TL * plane), och);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        d_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'(i % 2);
            s_load  = 1'(~(i % 2));
            s_data  = 16'($urandom);
            d_valid = 1'b1;
            d_load  = 1'b1;
            tick();
            n_chk++;
            if ({s_we, s_done, s_size, s_addr, s_odata} !== '0) begin
                n_fail++;
                $display("FAIL reset_small cyc=%0d got we=%0b done=%0b size=%0d addr=%0d data=%0h want all 0",
                         i, s_we, s_done, s_size, s_addr, s_odata);
            end
            n_chk++;
            if ({d_we, d_done, d_size, d_addr, d_odata} !== '0) begin
                n_fail++;
                $display("FAIL reset_dflt cyc=%0d got we=%0b done=%0b size=%0d addr=%0d want all 0",
                         i, d_we, d_done, d_size, d_addr);
            end
        end
        s_valid = 1'b0; s_load = 1'b0; d_valid = 1'b0; d_load = 1'b0;
        s_rst_n = 1'b1;
        d_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = 16'($urandom);
            tick();
            n_chk++;
            if (s_we !== 1'b0 || s_done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_valid cyc=%0d got we=%0b done=%0b want 0 0", i, s_we, s_done);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_layer_small(input int gap_pct, input bit mid_load, input bit end_load,
                                    input string tag);
        logic [15:0] exp_q[$];
        logic [15:0] dat;
        logic        v;
        int          k, w, cyc, ndone;
        k = 0; w = 0; cyc = 0; ndone = 0;
        s_load = 1'b1;
        s_valid = 1'b0;
        tick();
        s_load = 1'b0;
        n_chk++;
        if (s_we !== 1'b0 || s_size !== 5'(m_gsize(0, S_OCH))) begin
            n_fail++;
            $display("FAIL %s_after_load got we=%0b size=%0d want 0 %0d", tag, s_we, s_size, m_gsize(0, S_OCH));
        end
        while (w < S_TOT && cyc < 2000) begin
            v   = (k < S_TOT) && ($urandom_range(0, 99) >= gap_pct);
            dat = 16'($urandom);
            s_valid = v;
            s_data  = dat;
            s_load  = (mid_load && k == 37) || (end_load && v && k == S_TOT - 1);
            if (v) begin
                exp_q.push_back(dat);
                k++;
            end
            tick();
            cyc++;
            s_load = 1'b0;
            n_chk++;
            if (s_we !== v) begin
                n_fail++;
                $display("FAIL %s_we w=%0d got %0b want %0b", tag, w, s_we, v);
            end
            if (v) begin
                n_chk++;
                if (s_addr !== 7'(m_addr(w, S_OSZ, S_OCH))) begin
                    n_fail++;
                    $display("FAIL %s_addr w=%0d got %0d want %0d", tag, w, s_addr, m_addr(w, S_OSZ, S_OCH));
                end
                n_chk++;
                if (s_odata !== exp_q[w]) begin
                    n_fail++;
                    $display("FAIL %s_data w=%0d got %0h want %0h", tag, w, s_odata, exp_q[w]);
                end
                n_chk++;
                if (s_size !== 5'(m_size_at(w, S_OSZ, S_OCH))) begin
                    n_fail++;
                    $display("FAIL %s_size w=%0d got %0d want %0d", tag, w, s_size, m_size_at(w, S_OSZ, S_OCH));
                end
                n_chk++;
                if (s_done !== (w == S_TOT - 1)) begin
                    n_fail++;
                    $display("FAIL %s_done w=%0d got %0b want %0b", tag, w, s_done, (w == S_TOT - 1));
                end
                w++;
            end else begin
                n_chk++;
                if (s_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_done_idle w=%0d got 1 want 0", tag, w);
                end
            end
            if (s_done === 1'b1) ndone++;
        end
        n_chk++;
        if (w != S_TOT) begin
            n_fail++;
            $display("FAIL %s_timeout got %0d writes want %0d", tag, w, S_TOT);
        end
        // Layer finished: further valids (even after a late load) must not write.
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 16'($urandom);
            tick();
            if (s_done === 1'b1) ndone++;
            n_chk++;
            if (s_we !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_post_we cyc=%0d got 1 want 0", tag, i);
            end
        end
        s_valid = 1'b0;
        n_chk++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL %s_done_count got %0d want 1", tag, ndone);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        k = 0;
        s_load = 1'b1;
        tick();
        s_load = 1'b0;
        while (k < 30) begin
            s_valid = 1'b1;
            s_data  = 16'($urandom);
            k++;
            tick();
        end
        s_rst_n = 1'b0;
        tick();
        n_chk++;
        if ({s_we, s_done, s_size, s_addr, s_odata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got we=%0b done=%0b size=%0d addr=%0d data=%0h want all 0",
                     s_we, s_done, s_size, s_addr, s_odata);
        end
        s_rst_n = 1'b1;
        s_valid = 1'b0;
        tick();
        n_chk++;
        if (s_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle_we got 1 want 0");
        end
        test_layer_small(0, 1'b0, 1'b0, "restart");
    endtask

    task automatic test_default_layer();
        logic [15:0] exp_q[$];
        logic [15:0] dat;
        int          k, w, cyc, ndone, max_addr, bad;
        k = 0; w = 0; cyc = 0; ndone = 0; max_addr = 0; bad = 0;
        d_load = 1'b1;
        tick();
        d_load = 1'b0;
        while (w < D_TOT && cyc < 14000) begin
            d_valid = (k < D_TOT);
            dat     = 16'($urandom);
            d_data  = dat;
            if (k < D_TOT) begin
                exp_q.push_back(dat);
                k++;
            end
            tick();
            cyc++;
            if (d_done === 1'b1) ndone++;
            if (d_we === 1'b1) begin
                if (int'(d_addr) > max_addr) max_addr = int'(d_addr);
                n_chk++;
                if (d_addr !== 14'(m_addr(w, D_OSZ, D_OCH)) || d_odata !== exp_q[w]) begin
                    n_fail++;
                    if (bad < 8)
                        $display("FAIL dflt_write w=%0d got addr=%0d data=%0h want addr=%0d data=%0h",
                                 w, d_addr, d_odata, m_addr(w, D_OSZ, D_OCH), exp_q[w]);
                    bad++;
                end
                if (w == 0 || w == TL * D_OSZ * D_OSZ - 2 || w == TL * D_OSZ * D_OSZ - 1 || w == D_TOT - 1) begin
                    n_chk++;
                    if (d_size !== 5'(m_size_at(w, D_OSZ, D_OCH))) begin
                        n_fail++;
                        $display("FAIL dflt_size w=%0d got %0d want %0d", w, d_size, m_size_at(w, D_OSZ, D_OCH));
                    end
                end
                if (w == D_TOT - 1) begin
                    n_chk++;
                    if (d_done !== 1'b1 || d_addr !== 14'(D_TOT - 1)) begin
                        n_fail++;
                        $display("FAIL dflt_last got done=%0b addr=%0d want 1 %0d", d_done, d_addr, D_TOT - 1);
                    end
                end
                w++;
            end
        end
        d_valid = 1'b0;
        tick();
        if (d_done === 1'b1) ndone++;
        n_chk++;
        if (w != D_TOT) begin
            n_fail++;
            $display("FAIL dflt_write_count got %0d want %0d", w, D_TOT);
        end
        n_chk++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL dflt_done_count got %0d want 1", ndone);
        end
        n_chk++;
        if (max_addr > D_TOT - 1) begin
            n_fail++;
            $display("FAIL dflt_max_addr got %0d want <= %0d", max_addr, D_TOT - 1);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        s_rst_n = 1'b0; s_load = 1'b0; s_valid = 1'b0; s_data = '0;
        d_rst_n = 1'b0; d_load = 1'b0; d_valid = 1'b0; d_data = '0;
        test_reset();
        test_idle_valid();
        test_layer_small(0, 1'b0, 1'b0, "stream");
        test_layer_small(40, 1'b0, 1'b0, "bubbles");
        test_layer_small(25, 1'b1, 1'b1, "ignored_load");
        test_reset_mid();
        test_default_layer();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
